// File: rtl/ice_param_pkg.sv
// Shared constants, state encoding and parameter-table slicing helpers
// for the ICE parameter register file.
package ice_param_pkg;

  localparam logic [7:0] ACK_CODE      = 8'h00;
  localparam logic [7:0] NAK_CODE      = 8'h01;
  localparam logic [7:0] DEF_QUERY_CMD = 8'h50;
  localparam logic [7:0] DEF_SET_CMD   = 8'h70;

  // Upper bound on table size; flat tables are widened to this before slicing.
  localparam int MAX_P = 16;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_EID         = 3'd1;
  localparam logic [2:0] S_LEN         = 3'd2;
  localparam logic [2:0] S_SEL         = 3'd3;
  localparam logic [2:0] S_DATA        = 3'd4;
  localparam logic [2:0] S_RESP        = 3'd5;
  localparam logic [2:0] S_COMMIT_WAIT = 3'd6;

  function automatic logic [7:0] sel_at(input logic [8*MAX_P-1:0] flat, input int i);
    return flat[8*i +: 8];
  endfunction

  function automatic logic [2:0] len_at(input logic [3*MAX_P-1:0] flat, input int i);
    return flat[3*i +: 3];
  endfunction

  function automatic logic [31:0] byte_mask(input logic [2:0] len);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++)
      if (k < int'(len)) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // w is the per-parameter stride in bits; the result is clipped to len bytes.
  function automatic logic [31:0] rst_at(input logic [32*MAX_P-1:0] flat, input int w,
                                         input int i, input logic [2:0] len);
    return flat[w*i +: 32] & byte_mask(len);
  endfunction

endpackage

// File: rtl/param_resp_serializer.sv
// Emits one {code, eid, N, payload MSB-first} response frame, one byte per
// cycle in which resp_ready_i is high; done_o marks the final byte.
module param_resp_serializer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [7:0]   code_i,
  input  logic [7:0]   eid_i,
  input  logic [2:0]   n_i,
  input  logic [W-1:0] value_i,
  input  logic         resp_ready_i,
  output logic [7:0]   resp_data_o,
  output logic         resp_latch_o,
  output logic         resp_frame_o,
  output logic         done_o
);

  logic [7:0]   code_q, eid_q;
  logic [2:0]   n_q, cnt_q, bi;
  logic [W-1:0] val_q;
  logic         vld_q, last;

  assign last         = (cnt_q == n_q + 3'd2);
  assign bi           = n_q + 3'd2 - cnt_q;
  assign resp_latch_o = vld_q & resp_ready_i;
  assign done_o       = resp_latch_o & last;
  assign resp_frame_o = vld_q;

  always_comb begin
    case (cnt_q)
      3'd0:    resp_data_o = code_q;
      3'd1:    resp_data_o = eid_q;
      3'd2:    resp_data_o = {5'd0, n_q};
      default: resp_data_o = 8'(val_q >> {bi, 3'b000});
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
      eid_q  <= '0;
      n_q    <= '0;
      val_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else if (load_i) begin
      code_q <= code_i;
      eid_q  <= eid_i;
      n_q    <= n_i;
      val_q  <= value_i;
      cnt_q  <= '0;
      vld_q  <= 1'b1;
    end else if (resp_latch_o) begin
      if (last) vld_q <= 1'b0;
      else      cnt_q <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/param_regfile_int.sv
// Table-driven ICE parameter register file: parses query/set frames, answers
// with ACK/NAK frames and commits buffered writes when the consumer allows.
module param_regfile_int
  import ice_param_pkg::*;
#(
  parameter int                                NUM_PARAMS = 4,
  parameter int                                MAX_BYTES  = 3,
  parameter logic [7:0]                        QUERY_CMD  = DEF_QUERY_CMD,
  parameter logic [7:0]                        SET_CMD    = DEF_SET_CMD,
  parameter logic [8*NUM_PARAMS-1:0]           PARAM_SEL  = {NUM_PARAMS{8'h00}},
  parameter logic [3*NUM_PARAMS-1:0]           PARAM_LEN  = {NUM_PARAMS{3'd1}},
  parameter logic [8*MAX_BYTES*NUM_PARAMS-1:0] PARAM_RST  = '0,
  parameter logic [NUM_PARAMS-1:0]             PARAM_RO   = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          ma_data,
  input  logic                                ma_data_valid,
  input  logic                                ma_frame_valid,
  input  logic [8*MAX_BYTES*NUM_PARAMS-1:0]   ro_in,
  input  logic                                commit_allow,
  input  logic                                resp_ready,
  output logic [7:0]                          resp_data,
  output logic                                resp_data_latch,
  output logic                                resp_frame_valid,
  output logic [8*MAX_BYTES*NUM_PARAMS-1:0]   param_value,
  output logic [NUM_PARAMS-1:0]               param_updated,
  output logic                                busy
);

  localparam int W     = 8*MAX_BYTES;
  localparam int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam logic [8*MAX_P-1:0]  SEL_EXT = (8*MAX_P)'(PARAM_SEL);
  localparam logic [3*MAX_P-1:0]  LEN_EXT = (3*MAX_P)'(PARAM_LEN);
  localparam logic [32*MAX_P-1:0] RST_EXT = (32*MAX_P)'(PARAM_RST);

  logic [2:0]       state_q, state_d;
  logic             frame_q, is_set_q, is_set_d, ack_set_q, ack_set_d;
  logic [7:0]       eid_q, eid_d, len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d, hit_idx;
  logic [2:0]       cnt_q, cnt_d, hit_len, ld_n;
  logic [W-1:0]     stage_q, stage_d, hit_val, ld_val;
  logic [W-1:0]     param_q [NUM_PARAMS];
  logic [W-1:0]     shadow_q[NUM_PARAMS];
  logic [NUM_PARAMS-1:0] upd_q;
  logic [7:0]       ld_code;
  logic             hit, hit_ro, ld, start_nak, shadow_we, commit, ser_done, frame_rise;

  assign frame_rise    = ma_frame_valid & ~frame_q;
  assign busy          = (state_q != S_IDLE);
  assign param_updated = upd_q;

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_out
    assign param_value[W*g +: W] = param_q[g];
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0; hit_idx = '0; hit_len = '0; hit_ro = 1'b0; hit_val = '0;
    for (int i = NUM_PARAMS-1; i >= 0; i--) begin
      if (sel_at(SEL_EXT, i) == ma_data) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        hit_len = len_at(LEN_EXT, i);
        hit_ro  = PARAM_RO[i];
        hit_val = PARAM_RO[i] ? ro_in[W*i +: W] : param_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q; is_set_d = is_set_q; ack_set_d = ack_set_q;
    eid_d = eid_q; len_d = len_q; idx_d = idx_q; cnt_d = cnt_q; stage_d = stage_q;
    ld = 1'b0; ld_code = ACK_CODE; ld_n = '0; ld_val = '0;
    start_nak = 1'b0; shadow_we = 1'b0; commit = 1'b0;
    case (state_q)
      S_IDLE: if (frame_rise && (ma_data == QUERY_CMD || ma_data == SET_CMD)) begin
        is_set_d = (ma_data == SET_CMD);
        state_d  = S_EID;
      end
      S_EID: if (!ma_frame_valid) start_nak = 1'b1;
             else if (ma_data_valid) begin eid_d = ma_data; state_d = S_LEN; end
      S_LEN: if (!ma_frame_valid) start_nak = 1'b1;
             else if (ma_data_valid) begin len_d = ma_data; state_d = S_SEL; end
      S_SEL: if (!ma_frame_valid) start_nak = 1'b1;
             else if (ma_data_valid) begin
        if (!hit || (is_set_q && (hit_ro || len_q != {5'd0, hit_len} + 8'd1))) begin
          start_nak = 1'b1;
        end else if (!is_set_q) begin
          ld = 1'b1; ld_n = hit_len; ld_val = hit_val; ack_set_d = 1'b0; state_d = S_RESP;
        end else begin
          idx_d = hit_idx; cnt_d = hit_len; stage_d = '0; state_d = S_DATA;
        end
      end
      S_DATA: if (!ma_frame_valid) start_nak = 1'b1;
              else if (ma_data_valid) begin
        stage_d = (stage_q << 8) | W'(ma_data);
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          shadow_we = 1'b1; ld = 1'b1; ack_set_d = 1'b1; state_d = S_RESP;
        end
      end
      S_RESP: if (ser_done) state_d = ack_set_q ? S_COMMIT_WAIT : S_IDLE;
      S_COMMIT_WAIT: if (commit_allow) begin commit = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
    if (start_nak) begin
      ld = 1'b1; ld_code = NAK_CODE; ld_n = '0; ack_set_d = 1'b0; state_d = S_RESP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE; frame_q <= 1'b0; is_set_q <= 1'b0; ack_set_q <= 1'b0;
      eid_q <= '0; len_q <= '0; idx_q <= '0; cnt_q <= '0; stage_q <= '0;
    end else begin
      state_q <= state_d; frame_q <= ma_frame_valid; is_set_q <= is_set_d;
      ack_set_q <= ack_set_d; eid_q <= eid_d; len_q <= len_d; idx_q <= idx_d;
      cnt_q <= cnt_d; stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        param_q[i]  <= W'(rst_at(RST_EXT, W, i, len_at(LEN_EXT, i)));
        shadow_q[i] <= W'(rst_at(RST_EXT, W, i, len_at(LEN_EXT, i)));
      end
      upd_q <= '0;
    end else begin
      upd_q <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (shadow_we && IDX_W'(i) == idx_q) shadow_q[i] <= stage_d;
        if (commit && IDX_W'(i) == idx_q) begin
          param_q[i] <= shadow_q[i];
          upd_q[i]   <= 1'b1;
        end
      end
    end
  end

  param_resp_serializer #(.W(W)) u_ser (
    .clk          (clk),
    .rst          (rst),
    .load_i       (ld),
    .code_i       (ld_code),
    .eid_i        (eid_q),
    .n_i          (ld_n),
    .value_i      (ld_val),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_latch_o (resp_data_latch),
    .resp_frame_o (resp_frame_valid),
    .done_o       (ser_done)
  );

endmodule

// File: tb/tb_param_regfile_int.sv
// Directed bench for param_regfile_int: query/set/commit, NAK cases,
// response backpressure, busy-frame rejection and asynchronous reset.
module tb_param_regfile_int;

  localparam int P = 4;
  localparam int W = 24;
  localparam logic [W*P-1:0] RST_VIEW = {24'h000077, 24'h0000FF, 24'h00ABCD, 24'h30D400};

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     ma_data = 8'h00;
  logic           ma_data_valid = 1'b0;
  logic           ma_frame_valid = 1'b0;
  logic [W*P-1:0] ro_in = {24'h000000, 24'h00005A, 24'h000000, 24'h000000};
  logic           commit_allow = 1'b0;
  logic           resp_ready = 1'b1;
  logic [7:0]     resp_data;
  logic           resp_data_latch, resp_frame_valid, busy;
  logic [W*P-1:0] param_value;
  logic [P-1:0]   param_updated;

  int tests = 0, fails = 0, frames = 0, hold_err = 0;
  logic [7:0] rx[$];
  logic       prev_fv = 1'b0, prev_hold = 1'b0, held;
  logic [7:0] prev_dat = 8'h00;
  int         f0;

  param_regfile_int #(
    .NUM_PARAMS (4),
    .MAX_BYTES  (3),
    .QUERY_CMD  (8'h50),
    .SET_CMD    (8'h70),
    .PARAM_SEL  ({8'h42, 8'h52, 8'h43, 8'h42}),
    .PARAM_LEN  ({3'd1, 3'd1, 3'd2, 3'd3}),
    .PARAM_RST  ({24'h000077, 24'hFFFFFF, 24'h12ABCD, 24'h30D400}),
    .PARAM_RO   (4'b0100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ma_data          (ma_data),
    .ma_data_valid    (ma_data_valid),
    .ma_frame_valid   (ma_frame_valid),
    .ro_in            (ro_in),
    .commit_allow     (commit_allow),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .resp_data_latch  (resp_data_latch),
    .resp_frame_valid (resp_frame_valid),
    .param_value      (param_value),
    .param_updated    (param_updated),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (resp_data_latch) rx.push_back(resp_data);
      if (resp_frame_valid && !prev_fv) frames++;
      if (prev_hold && resp_frame_valid && resp_data !== prev_dat) hold_err++;
    end
    prev_fv   = resp_frame_valid;
    prev_hold = resp_frame_valid && !resp_ready;
    prev_dat  = resp_data;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [63:0] bytes, input int n, input bit hold_open);
    for (int k = 0; k < n; k++) begin
      tick();
      ma_frame_valid = 1'b1;
      ma_data_valid  = 1'b1;
      ma_data        = bytes[8*(n-1-k) +: 8];
    end
    tick();
    ma_data_valid = 1'b0;
    ma_data       = 8'h00;
    if (!hold_open) ma_frame_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [63:0] exp, input int n, input bit toggle);
    logic [63:0] w;
    int c;
    c = 0;
    while (!(rx.size() >= n && !resp_frame_valid) && c < 100) begin
      tick();
      c++;
      if (toggle) resp_ready = ~resp_ready;
    end
    resp_ready = 1'b1;
    chk({tag, " len"}, 128'(rx.size()), 128'(n));
    w = '0;
    foreach (rx[k]) w = (w << 8) | 64'(rx[k]);
    chk({tag, " bytes"}, 128'(w), 128'(exp));
    rx.delete();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_value", 128'(param_value), 128'(RST_VIEW));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_fv", 128'(resp_frame_valid), 128'(0));
    chk("rst_latch", 128'(resp_data_latch), 128'(0));
    chk("rst_upd", 128'(param_updated), 128'(0));
    rst = 1'b1;
    repeat (2) tick();

    // Query p0; p3 shares selector 'B' but the lower index must answer.
    send_frame({8'h50, 8'h07, 8'h01, 8'h42}, 4, 1'b0);
    chk("q0_latency", 128'(resp_frame_valid), 128'(1));
    expect_resp("q0", {8'h00, 8'h07, 8'h03, 8'h30, 8'hD4, 8'h00}, 6, 1'b0);

    send_frame({8'h50, 8'h0A, 8'h01, 8'h43}, 4, 1'b0);
    expect_resp("q1", {8'h00, 8'h0A, 8'h02, 8'hAB, 8'hCD}, 5, 1'b0);

    send_frame({8'h50, 8'h0B, 8'h01, 8'h52}, 4, 1'b0);
    expect_resp("q2_ro", {8'h00, 8'h0B, 8'h01, 8'h5A}, 4, 1'b0);

    // Set p0 with commit held off for 10 cycles.
    send_frame({8'h70, 8'h09, 8'h04, 8'h42, 8'h12, 8'h34, 8'h56}, 7, 1'b0);
    expect_resp("set0", {8'h00, 8'h09, 8'h00}, 3, 1'b0);
    chk("cw_busy", 128'(busy), 128'(1));
    held = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (param_value[23:0] !== 24'h30D400 || param_updated !== 4'b0000) held = 1'b0;
    end
    chk("no_early_commit", 128'(held), 128'(1));
    commit_allow = 1'b1;
    tick();
    chk("commit_val", 128'(param_value[23:0]), 128'(24'h123456));
    chk("commit_pulse", 128'(param_updated), 128'(4'b0001));
    commit_allow = 1'b0;
    tick();
    chk("pulse_1cyc", 128'(param_updated), 128'(4'b0000));
    chk("idle_after", 128'(busy), 128'(0));

    send_frame({8'h70, 8'h0C, 8'h04, 8'h99, 8'h01, 8'h02, 8'h03}, 7, 1'b0);
    expect_resp("nak_sel", {8'h01, 8'h0C, 8'h00}, 3, 1'b0);
    send_frame({8'h70, 8'h0D, 8'h02, 8'h52, 8'hAA}, 5, 1'b0);
    expect_resp("nak_ro", {8'h01, 8'h0D, 8'h00}, 3, 1'b0);
    send_frame({8'h70, 8'h0E, 8'h03, 8'h42, 8'hAA, 8'hBB, 8'hCC}, 7, 1'b0);
    expect_resp("nak_len", {8'h01, 8'h0E, 8'h00}, 3, 1'b0);
    send_frame({8'h70, 8'h0F, 8'h04, 8'h42, 8'hAA}, 5, 1'b0);
    expect_resp("nak_early", {8'h01, 8'h0F, 8'h00}, 3, 1'b0);
    repeat (2) tick();
    chk("nak_busy", 128'(busy), 128'(0));
    chk("nak_values", 128'(param_value),
        128'({24'h000077, 24'h0000FF, 24'h00ABCD, 24'h123456}));

    send_frame({8'h33, 8'h07, 8'h01, 8'h42}, 4, 1'b0);
    repeat (10) tick();
    chk("bad_cmd_rx", 128'(rx.size()), 128'(0));
    chk("bad_cmd_busy", 128'(busy), 128'(0));

    // Backpressure: resp_ready alternates while the frame drains.
    f0 = frames;
    send_frame({8'h50, 8'h10, 8'h01, 8'h43}, 4, 1'b0);
    expect_resp("q1_bp", {8'h00, 8'h10, 8'h02, 8'hAB, 8'hCD}, 5, 1'b1);
    chk("bp_frames", 128'(frames - f0), 128'(1));
    chk("bp_hold", 128'(hold_err), 128'(0));

    // A frame arriving during COMMIT_WAIT must be ignored entirely.
    send_frame({8'h70, 8'h11, 8'h03, 8'h43, 8'hBE, 8'hEF}, 6, 1'b0);
    expect_resp("set1", {8'h00, 8'h11, 8'h00}, 3, 1'b0);
    send_frame({8'h50, 8'h12, 8'h01, 8'h42}, 4, 1'b0);
    repeat (10) tick();
    chk("busy_ign_rx", 128'(rx.size()), 128'(0));
    chk("busy_ign_busy", 128'(busy), 128'(1));
    commit_allow = 1'b1;
    tick();
    chk("commit1_val", 128'(param_value[47:24]), 128'(24'h00BEEF));
    chk("commit1_pulse", 128'(param_updated), 128'(4'b0010));
    commit_allow = 1'b0;

    // Asynchronous reset in the middle of DATA.
    send_frame({8'h70, 8'h13, 8'h04, 8'h42, 8'h11}, 5, 1'b1);
    chk("mid_busy", 128'(busy), 128'(1));
    #3 rst = 1'b0;
    #1;
    chk("arst_fv", 128'(resp_frame_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_value", 128'(param_value), 128'(RST_VIEW));
    chk("arst_upd", 128'(param_updated), 128'(0));
    tick();
    rst = 1'b1;
    ma_frame_valid = 1'b0;
    rx.delete();
    repeat (2) tick();

    send_frame({8'h50, 8'h14, 8'h01, 8'h42}, 4, 1'b0);
    expect_resp("q0_post", {8'h00, 8'h14, 8'h03, 8'h30, 8'hD4, 8'h00}, 6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_regfile_int.md
Name: param_regfile_int

Overview:
- Generic, table-driven parameter register file on the ICE master input bus. Successor to the fixed per-feature query/set handler.
- Serves NUM_PARAMS parameters, each selected by a one-byte selector character, with per-parameter byte length, reset value and read-only flag.
- Answers query/set commands with ACK/NAK response frames on a byte-stream interface that feeds an external message FIFO.
- Buffers writes in shadow registers and commits them only when the consumer signals it is safe.

Parameters:
- NUM_PARAMS, 4, number of parameters P (1..16).
- MAX_BYTES, 3, widest parameter in bytes B (1..4); W = 8*B.
- QUERY_CMD, 8'h50, command byte for a query.
- SET_CMD, 8'h70, command byte for a set.
- PARAM_SEL, {P{8'h00}}, flat [8P-1:0]; selector character of parameter i at [8i+7:8i].
- PARAM_LEN, {P{3'd1}}, flat [3P-1:0]; length of parameter i in bytes, 1..B.
- PARAM_RST, 0, flat [WP-1:0]; reset value of parameter i.
- PARAM_RO, 0, [P-1:0]; bit i set means parameter i is read-only and sourced from ro_in.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ma_data  in  8  master bus byte.
- ma_data_valid  in  1  byte strobe.
- ma_frame_valid  in  1  frame envelope.
- ro_in  in  W*P  live values for read-only parameters.
- commit_allow  in  1  consumer is idle; shadow values may be committed.
- resp_ready  in  1  downstream FIFO can accept a byte.
- resp_data  out  8  response byte.
- resp_data_latch  out  1  byte strobe.
- resp_frame_valid  out  1  response frame envelope.
- param_value  out  W*P  committed values, zero-extended above the parameter's length.
- param_updated  out  P  one-cycle pulse on commit.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - param_value = PARAM_RST, masked to each parameter's length; shadows likewise.
  - All strobes, resp_frame_valid and busy are 0.
- Frame start:
  - A rising edge of ma_frame_valid while in IDLE latches ma_data as the command.
  - Command equal to QUERY_CMD or SET_CMD: go to EID. Any other command: stay in IDLE and ignore the frame.
  - A rising edge while not IDLE is ignored, and so are all bytes of that frame.
- Input byte order (each byte qualified by ma_data_valid): EID (latched), LEN (latched), SEL, then DATA bytes (set only).
- SEL lookup:
  - Lowest-index parameter whose PARAM_SEL matches wins.
  - No match gives NAK.
  - Set to a read-only parameter gives NAK.
- Set length check: LEN must equal 1 + PARAM_LEN[i], otherwise NAK. The check happens once SEL is latched.
- DATA capture:
  - Bytes shift MSB-first into a staging register, PARAM_LEN[i] bytes.
  - The staging register is copied to shadow[i] when the last byte arrives.
- Early end: ma_frame_valid falling before the expected bytes are complete gives NAK, and the shadow is unchanged.
- Response frame (state RESP):
  - resp_frame_valid is high for the whole frame and low for at least 1 cycle between frames.
  - Bytes are {code, EID, N, payload}: code 8'h00 = ACK, 8'h01 = NAK. N is the payload byte count.
  - Query ACK: N = PARAM_LEN[i]; payload is the value, MSB first. The value is ro_in for read-only parameters and the committed value otherwise, sampled on entry to RESP.
  - Set ACK and NAK: N = 0, no payload.
- Byte handshake:
  - resp_data_latch is asserted only in cycles where resp_ready=1, one byte per strobe.
  - resp_data is stable while resp_ready=0.
- Commit:
  - After a set ACK frame ends, enter COMMIT_WAIT.
  - In the first cycle with commit_allow=1: param_value[i] <= shadow[i], param_updated[i] pulses for 1 cycle, return to IDLE.
  - The commit takes effect in the same cycle the pulse is seen.
- Latency: the first response byte is presented on the cycle after the final input byte, or after the early-end detect.
- States: IDLE, EID, LEN, SEL, DATA, RESP, COMMIT_WAIT.
- Response byte counter: 3 bits, wide enough for 3+B bytes.

Decomposition:
- Shared package (ice_param_pkg) holds:
  - ACK/NAK code constants.
  - Default QUERY_CMD/SET_CMD values.
  - The state enumeration.
  - Helper functions to slice PARAM_SEL, PARAM_LEN and PARAM_RST.
- One sub-module, param_resp_serializer: loads {code, eid, N, value}; emits the framed bytes under resp_ready; reports done.

Test Plan:
- Reset with PARAM_RST[0]=24'h30D400, LEN 3 -> param_value[0]=24'h30D400, all strobes 0, busy=0.
- Query frame {50,EID 07,LEN 01,SEL} for parameter 0 -> response {00,07,03,30,D4,00} with resp_ready held 1.
- Set frame {70,09,04,SEL,12,34,56}, commit_allow=0 for 10 cycles then 1 -> ACK {00,09,00}; param_value unchanged until commit_allow=1; then value 24'h123456 and param_updated[0] pulses for exactly 1 cycle.
- Error frames -> NAK {01,EID,00}, shadow unchanged:
  - unknown SEL;
  - set to a read-only parameter;
  - LEN mismatch;
  - ma_frame_valid dropped after 1 data byte.
- Query with resp_ready toggling 1/0 every cycle -> same 6 bytes in order, no duplicates; resp_frame_valid never drops mid-frame.
- Second frame starting while busy, and rst asserted mid-DATA -> second frame ignored; on reset all values return to PARAM_RST and resp_frame_valid=0 immediately.
